// File: rtl/uart_puf_framer.sv
// uart_puf_framer: UART <-> PUF protocol stage.
// Sync-framed challenge in, sync-framed response out.
module uart_puf_framer #(
    parameter int          CHAL_BYTES     = 8,
    parameter int          RESP_BYTES     = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rx_received,
    input  logic [7:0]              i_rx_byte,
    input  logic                    i_rx_error,
    input  logic                    i_tx_busy,
    output logic                    o_tx_transmit,
    output logic [7:0]              o_tx_byte,
    output logic [CHAL_BYTES*8-1:0] o_chal,
    output logic                    o_puf_start,
    input  logic                    i_puf_done,
    input  logic [RESP_BYTES*8-1:0] i_puf_resp,
    output logic                    o_busy,
    output logic                    o_frame_err
);

    localparam logic [4:0]  LP_CHAL_LAST = 5'(CHAL_BYTES - 1);
    localparam logic [4:0]  LP_TX_LAST   = 5'(RESP_BYTES);
    localparam logic [31:0] LP_TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_START,
        S_WAIT,
        S_TX,
        S_TXB,
        S_TXD
    } state_t;

    state_t                    r_state;
    logic [4:0]                r_cnt;
    logic [4:0]                r_txcnt;
    logic [31:0]               r_timer;
    logic [RESP_BYTES*8-1:0]   r_resp;
    logic [CHAL_BYTES*8-1:0]   r_chal;
    logic [7:0]                r_tx_byte;
    logic                      r_tx_transmit;
    logic                      r_puf_start;
    logic                      r_busy;
    logic                      r_frame_err;

    logic w_sync;
    logic w_timeout;
    logic w_tx_last;

    assign w_sync    = i_rx_received && (i_rx_byte == SYNC_BYTE);
    assign w_timeout = (r_timer == LP_TO_LAST);
    assign w_tx_last = (r_txcnt == LP_TX_LAST);

    assign o_tx_transmit = r_tx_transmit;
    assign o_tx_byte     = r_tx_byte;
    assign o_chal        = r_chal;
    assign o_puf_start   = r_puf_start;
    assign o_busy        = r_busy;
    assign o_frame_err   = r_frame_err;

    // Transaction FSM: all outputs and datapath registers live here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_txcnt       <= '0;
            r_timer       <= '0;
            r_resp        <= '0;
            r_chal        <= '0;
            r_tx_byte     <= '0;
            r_tx_transmit <= 1'b0;
            r_puf_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_tx_transmit <= 1'b0;
            r_puf_start   <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sync) begin
                        r_state <= S_RX;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RX: begin
                    if (i_rx_error) begin
                        r_frame_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (i_rx_received) begin
                        for (int i = 0; i < CHAL_BYTES; i++) begin
                            if (r_cnt == 5'(i)) begin
                                r_chal[8*i +: 8] <= i_rx_byte;
                            end
                        end
                        r_timer <= '0;
                        if (r_cnt == LP_CHAL_LAST) begin
                            r_state <= S_START;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_START: begin
                    r_puf_start <= 1'b1;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_puf_done) begin
                        r_resp  <= i_puf_resp;
                        r_txcnt <= '0;
                        r_state <= S_TX;
                    end
                end
                S_TX: begin
                    if (!i_tx_busy) begin
                        r_tx_transmit <= 1'b1;
                        if (r_txcnt == 5'd0) begin
                            r_tx_byte <= SYNC_BYTE;
                        end else begin
                            r_tx_byte <= r_resp[7:0];
                            r_resp    <= r_resp >> 8;
                        end
                        r_state <= S_TXB;
                    end
                end
                S_TXB: begin
                    if (i_tx_busy) begin
                        r_state <= S_TXD;
                    end
                end
                S_TXD: begin
                    if (!i_tx_busy) begin
                        if (w_tx_last) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_txcnt <= r_txcnt + 5'd1;
                            r_state <= S_TX;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
